// File: rtl/xnor_serial_compare_ctrl.sv
// Bit-serial equality/match counter: streams operand bits LSB first to a shared
// external xnor gate and accumulates the returned match bits.
//
// state   | meaning
// S_IDLE  | waiting for start; operands ignored
// S_SHIFT | presenting bit pair, sampling xnor_in, WIDTH cycles
// S_DONE  | one-cycle completion pulse, results valid
module xnor_serial_compare_ctrl #(
   parameter int WIDTH = 8,
   localparam int CW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             bit_a,
   output logic             bit_b,
   input  logic             xnor_in,
   output logic             busy,
   output logic             done,
   output logic             equal,
   output logic [CW-1:0]    match_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sa_q;
   logic [WIDTH-1:0] sb_q;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    acc_q;
   logic [CW-1:0]    acc_d;
   logic [CW-1:0]    match_count_q;
   logic             equal_q;
   logic             last_bit;

   // acc_d includes the bit sampled on this edge, so the final load sees all WIDTH bits
   assign acc_d    = acc_q + CW'(xnor_in);
   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         sa_q          <= '0;
         sb_q          <= '0;
         cnt_q         <= '0;
         acc_q         <= '0;
         match_count_q <= '0;
         equal_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  sa_q    <= a;
                  sb_q    <= b;
                  cnt_q   <= '0;
                  acc_q   <= '0;
                  state_q <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               acc_q <= acc_d;
               sa_q  <= sa_q >> 1;
               sb_q  <= sb_q >> 1;
               cnt_q <= cnt_q + CW'(1);
               if (last_bit) begin
                  match_count_q <= acc_d;
                  equal_q       <= (acc_d == CW'(WIDTH));
                  state_q       <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bit_a       = (state_q == S_SHIFT) & sa_q[0];
   assign bit_b       = (state_q == S_SHIFT) & sb_q[0];
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign equal       = equal_q;
   assign match_count = match_count_q;

endmodule

// File: tb/tb_xnor_serial_compare_ctrl.sv
// Scoreboard bench for xnor_serial_compare_ctrl: expected results are queued at
// start acceptance and checked by an independent monitor on each done pulse.
module tb_xnor_serial_compare_ctrl;
   localparam int W  = 8;
   localparam int CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          bit_a, bit_b, xnor_in, busy, done, equal;
   logic [CW-1:0] match_count;
   logic          inv_gate = 1'b0;

   // inv_gate turns the external gate into xor, proving results come only from xnor_in
   assign xnor_in = ~(bit_a ^ bit_b) ^ inv_gate;

   xnor_serial_compare_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
      .bit_a(bit_a), .bit_b(bit_b), .xnor_in(xnor_in),
      .busy(busy), .done(done), .equal(equal), .match_count(match_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic eq;
      int   mc;
   } res_t;

   res_t exp_q[$];
   logic held_eq = 1'b0;
   int   held_mc = 0;
   bit   mon_en = 1'b0;
   logic prev_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int ref_matches(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic inv);
      int n = 0;
      for (int i = 0; i < W; i++)
         if ((x[i] == y[i]) != inv) n++;
      return n;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // A reset edge discards any pending compare and clears the held results.
   always @(posedge clk) begin
      if (reset) begin
         exp_q.delete();
         held_eq = 1'b0;
         held_mc = 0;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (done === 1'b1) begin
            chk("done_one_cycle", prev_done, 1'b0);
            if (exp_q.size() == 0) begin
               chk("unexpected_done_queue", exp_q.size(), 1);
            end else begin
               res_t r;
               r = exp_q.pop_front();
               chk("result_equal", equal, r.eq);
               chk("result_count", match_count, r.mc);
               held_eq = r.eq;
               held_mc = r.mc;
            end
         end else begin
            chk("hold_equal", equal, held_eq);
            chk("hold_count", match_count, held_mc);
         end
         prev_done = done;
      end
   end

   task automatic run_compare(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                              input bit hold, input logic [W-1:0] ha,
                              input logic [W-1:0] hb, input logic inv);
      res_t r;
      int   n;
      inv_gate = inv;
      a = ta;
      b = tb_;
      start = 1'b1;
      @(posedge clk);
      n = ref_matches(ta, tb_, inv);
      r.eq = (n == W);
      r.mc = n;
      exp_q.push_back(r);
      #1;
      if (hold) begin
         a = ha;
         b = hb;
      end else begin
         start = 1'b0;
         a = W'($urandom);
         b = W'($urandom);
      end
      for (int i = 0; i < W; i++) begin
         chk("shift_bit_a", bit_a, ta[i]);
         chk("shift_bit_b", bit_b, tb_[i]);
         chk("shift_busy", busy, 1'b1);
         step();
      end
      chk("done_latency", done, 1'b1);
      chk("done_busy", busy, 1'b1);
      chk("done_bits", {bit_a, bit_b}, 2'b00);
      step();
      start = 1'b0;
      chk("idle_busy", busy, 1'b0);
      chk("idle_done", done, 1'b0);
      chk("idle_bits", {bit_a, bit_b}, 2'b00);
   endtask

   task automatic abort_compare(input logic [W-1:0] ta, input logic [W-1:0] tb_);
      inv_gate = 1'b0;
      a = ta;
      b = tb_;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_outputs", {busy, done, equal, bit_a, bit_b}, 5'b0);
      chk("abort_count", match_count, 0);
      repeat (W + 3) step();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {busy, done, equal, bit_a, bit_b}, 5'b0);
      chk("reset_count", match_count, 0);
      reset = 1'b0;
      mon_en = 1'b1;

      run_compare(8'hA5, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0);
      run_compare(8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      run_compare(8'hF0, 8'hF1, 1'b0, 8'h00, 8'h00, 1'b0);
      run_compare(8'h0F, 8'h0F, 1'b1, 8'h00, 8'hFF, 1'b0);
      run_compare(8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 1'b0);
      run_compare(8'h56, 8'h56, 1'b0, 8'h00, 8'h00, 1'b0);
      abort_compare(8'h5A, 8'hC3);
      run_compare(8'h3C, 8'h3C, 1'b0, 8'h00, 8'h00, 1'b0);

      for (int k = 0; k < 30; k++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
         run_compare(ra, rb, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                     1'($urandom_range(0, 3) == 0));
         repeat ($urandom_range(0, 2)) step();
      end

      repeat (W + 4) step();
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
